// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, idle line level and FSM state encoding.
// Used by both the receiver and the transmitter on the same link.
package uart_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam logic        LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous serial line.
// It resets to the idle line level, so a reset never looks like a start bit.
module uart_sync
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic rx_async,
  output logic rx_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= {SYNC_STAGES{LINE_IDLE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_async};
    end
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a hold-until-acknowledged VALID handshake.
// Defining UART_RX_PARITY_EN switches the frame to 8E1 and enables PARITY_ERR.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_EN,
  input  logic              RX_IN,
  input  logic              RX_ACK,
  output logic [DATA_W-1:0] RX_OUT,
  output logic              VALID,
  output logic              BUSY,
  output logic              FRAME_ERR,
  output logic              OVERRUN,
  output logic              PARITY_ERR
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CntHalf = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK     (CLK),
    .RST     (RST),
    .rx_async(RX_IN),
    .rx_sync (rx_s)
  );

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_out_q, rx_out_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              par_err_q, par_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_out_d    = rx_out_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    par_err_d   = 1'b0;
`endif

    if (valid_q && RX_ACK) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (RX_EN && (rx_s != LINE_IDLE)) begin
          state_d = StStart;
        end
      end
      StStart: begin
        bit_idx_d = '0;
        if (!RX_EN) begin
          state_d = StIdle;
        end else if (cnt_q == CntHalf) begin
          // A start bit that is high again at mid-bit was only a glitch.
          state_d = (rx_s == LINE_IDLE) ? StIdle : StData;
        end
      end
      StData: begin
        if (!RX_EN) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (!RX_EN) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          par_bad_d = rx_s ^ (^shift_q);
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (!RX_EN) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
`ifdef UART_RX_PARITY_EN
          par_err_d = par_bad_q;
`endif
          if (rx_s == LINE_IDLE) begin
            // An ACK in this same cycle frees the slot, so no overrun.
            rx_out_d  = shift_q;
            valid_d   = 1'b1;
            overrun_d = valid_q && !RX_ACK;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        if (rx_s == LINE_IDLE) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_out_q    <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_out_q    <= rx_out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign RX_OUT    = rx_out_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;
  assign BUSY      = (state_q == StStart) || (state_q == StData) ||
                     (state_q == StParity) || (state_q == StStop);
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = par_err_q;
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected bytes are queued as frames are sent
// and popped when the receiver presents a new byte.
module tb_uart_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBITS = 11;
  localparam int          PE_TOTAL = 1;
`else
  localparam int unsigned NBITS = 10;
  localparam int          PE_TOTAL = 0;
`endif
  localparam int LAT = SYNC + CPB / 2 + (NBITS - 1) * CPB + 1;

  logic       clk = 1'b0;
  logic       rst, rx_en, rx_in, rx_ack;
  logic [7:0] rx_out;
  logic       valid, busy, frame_err, overrun, parity_err;

  int n_total = 0, n_bad = 0;
  int cyc = 0, start_cyc = 0, lat = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int fe0, ov0, pe0;
  logic valid_prev = 1'b0, ack_seen = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  bit bad_par = 1'b0;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .RX_EN     (rx_en),
    .RX_IN     (rx_in),
    .RX_ACK    (rx_ack),
    .RX_OUT    (rx_out),
    .VALID     (valid),
    .BUSY      (busy),
    .FRAME_ERR (frame_err),
    .OVERRUN   (overrun),
    .PARITY_ERR(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    ack_seen <= rx_ack;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h required=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: counts flag cycles and pops the scoreboard on every new byte.
  always @(negedge clk) begin
    if (rst) begin
      valid_prev = 1'b0;
    end else begin
      if (frame_err)  fe_cnt++;
      if (overrun)    ov_cnt++;
      if (parity_err) pe_cnt++;
      if (valid && (!valid_prev || ack_seen || overrun)) begin
        if (!valid_prev) lat = cyc - start_cyc;
        check_eq("sb_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          check_eq("sb_byte", rx_out, exp_b);
        end
      end
      valid_prev = valid;
    end
  end

  // Every drive happens 2 time units after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    start_cyc = cyc;
    rx_in = 1'b0;
    tick(CPB);
    for (int k = 0; k < 8; k++) begin
      rx_in = data[k];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx_in = (^data) ^ bad_par;
    tick(CPB);
`endif
    rx_in = stop;
    tick(CPB);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    check_eq("ack_clears_valid", valid, 0);
  endtask

  task automatic snap();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    pe0 = pe_cnt;
  endtask

  initial begin
    rst = 1'b1; rx_en = 1'b1; rx_in = 1'b1; rx_ack = 1'b0;
    tick(3);
    check_eq("rst_rx_out", rx_out, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_flags", {frame_err, overrun, parity_err}, 0);
    rst = 1'b0;
    tick(5);

    // Reset in the middle of a frame.
    rx_in = 1'b0;
    tick(50);
    check_eq("midframe_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_valid", valid, 0);
    check_eq("midrst_out", rx_out, 0);
    check_eq("midrst_flags", {frame_err, overrun, parity_err}, 0);
    tick(2);
    rx_in = 1'b1;
    rst = 1'b0;
    tick(20);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    check_eq("a5_valid", valid, 1);
    do_ack();
    tick(5);

    // Latency and ACK.
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    check_eq("3c_latency", lat, LAT);
    check_eq("3c_out", rx_out, 8'h3C);
    do_ack();
    tick(5);

    // Short low glitch on an idle line.
    snap();
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    tick(40);
    check_eq("glitch_busy", busy, 0);
    check_eq("glitch_valid", valid, 0);
    check_eq("glitch_fe", fe_cnt - fe0, 0);

    // Frame error, line stays low afterwards.
    snap();
    send_frame(8'h81, 1'b0);
    tick(20);
    check_eq("waithigh_busy", busy, 0);
    tick(20);
    rx_in = 1'b1;
    tick(20);
    check_eq("fe_pulses", fe_cnt - fe0, 1);
    check_eq("fe_valid", valid, 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    check_eq("55_out", rx_out, 8'h55);
    do_ack();
    tick(5);

    // Overrun without ACK.
    snap();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(2);
    check_eq("ov_pulses", ov_cnt - ov0, 1);
    check_eq("ov_out", rx_out, 8'h22);
    check_eq("ov_valid", valid, 1);
    do_ack();
    tick(5);

    // ACK in the completion cycle: no overrun.
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    snap();
    exp_q.push_back(8'h44);
    fork
      send_frame(8'h44, 1'b1);
      begin
        tick(LAT - 1);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
      end
    join
    check_eq("ackcomp_ov", ov_cnt - ov0, 0);
    check_eq("ackcomp_valid", valid, 1);
    check_eq("ackcomp_out", rx_out, 8'h44);
    do_ack();
    tick(5);

    // RX_EN dropped during data bit 3.
    snap();
    fork
      send_frame(8'h5A, 1'b1);
      begin
        tick(70);
        check_eq("en_busy_before", busy, 1);
        rx_en = 1'b0;
        tick(1);
        check_eq("en_busy_after", busy, 0);
      end
    join
    rx_en = 1'b1;
    tick(20);
    check_eq("en_valid", valid, 0);
    check_eq("en_fe", fe_cnt - fe0, 0);

`ifdef UART_RX_PARITY_EN
    snap();
    bad_par = 1'b1;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    bad_par = 1'b0;
    check_eq("par_pulses", pe_cnt - pe0, 1);
    check_eq("par_out", rx_out, 8'h07);
    check_eq("par_valid", valid, 1);
    do_ack();
    tick(5);
`endif

    check_eq("pe_total", pe_cnt, PE_TOTAL);
    check_eq("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver: 8N1 (8 data bits, no parity, 1 stop bit), LSB-first, line idle high. Oversamples RX_IN with CLKS_PER_BIT clocks per bit and samples mid-bit. Presents each received byte with a hold-until-acknowledged VALID handshake. Receive-side counterpart of the UART transmitter on the same link.

Parameters:
CLKS_PER_BIT, 16, clocks per serial bit; even, >= 4; HALF = CLKS_PER_BIT/2
SYNC_STAGES, 2, input synchronizer depth; >= 2

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous, active-high reset
RX_EN  input  1  receiver enable
RX_IN  input  1  asynchronous serial line
RX_ACK  input  1  consumer acknowledge; clears VALID
RX_OUT  output  8  received byte, stable while VALID=1
VALID  output  1  byte available, held until acknowledged
BUSY  output  1  high from start detect until stop sampled/abort
FRAME_ERR  output  1  one-cycle pulse: stop bit sampled 0
OVERRUN  output  1  one-cycle pulse: byte completed while VALID held, no ACK
PARITY_ERR  output  1  parity mismatch pulse (optional feature; else tied 0)

Behaviour:
- Reset (async): state IDLE; RX_OUT=0, VALID=0, BUSY=0, FRAME_ERR=0, OVERRUN=0, PARITY_ERR=0; synchronizer flops=1; counter and bit index=0.
- RX_S = RX_IN after SYNC_STAGES flops. All decisions use RX_S only.
- Counter CNT runs 0..CLKS_PER_BIT-1, cleared on every state change.
- IDLE: if RX_EN and RX_S=0 -> START (cycle t0), BUSY=1 next cycle.
- START: at CNT=HALF-1 (cycle t0+HALF), sample RX_S: 0 -> DATA; 1 -> false start, IDLE, BUSY=0, no flags.
- DATA: sample at CNT=CLKS_PER_BIT-1; bit k lands in shift[k] at t0+HALF+(k+1)*CLKS_PER_BIT; after bit 7 -> STOP.
- STOP: sample at t0+HALF+9*CLKS_PER_BIT. RX_S=1: load RX_OUT, set VALID, -> IDLE. RX_S=0: FRAME_ERR pulse, data discarded, -> WAIT_HIGH.
- WAIT_HIGH: stay until RX_S=1 (line break/glitch), then IDLE. BUSY=0 here.
- Flags and VALID become visible the cycle after the stop sample.
- Handshake: VALID cleared the cycle after RX_ACK sampled high. RX_ACK while VALID=0 is ignored.
- Completion with VALID=1 and RX_ACK=0: RX_OUT overwritten, VALID stays 1, OVERRUN pulses.
- Completion and RX_ACK in the same cycle: new byte loads, VALID stays 1, no OVERRUN.
- RX_EN low mid-frame (START/DATA/STOP): abort to IDLE next cycle, BUSY=0, no flags. VALID and RX_OUT are unaffected by RX_EN.
- Back-to-back frames: a start edge is detectable the cycle after return to IDLE (half-bit margin).
- Latency from RX_IN falling edge to VALID: SYNC_STAGES + HALF + 9*CLKS_PER_BIT + 1 cycles.

Optional Feature:
UART_RX_PARITY_EN: when defined, frame is 8E1. PARITY state between DATA and STOP samples one extra bit. Even parity mismatch (XOR of data and parity bit = 1) pulses PARITY_ERR with the stop-sample result; byte is still delivered with VALID. Latency grows by CLKS_PER_BIT. When undefined: no PARITY state, PARITY_ERR tied 0.

Decomposition:
- Package uart_pkg: state encoding enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH), DATA_W=8, stop/idle line level constant. Shared with the transmitter.
- One sub-module: uart_sync (SYNC_STAGES flop chain, reset value 1). Counter and FSM stay in uart_rx.

Test Plan:
- Reset mid-frame -> all outputs 0 immediately; next clean frame 0xA5 received correctly.
- Frame 0x3C at CLKS_PER_BIT=16 -> VALID at 2+8+144+1=155 cycles after falling edge, RX_OUT=0x3C; ACK -> VALID 0 next cycle.
- 4-cycle low glitch on idle line -> no BUSY after START rejection, no VALID, no flags.
- Frame 0x81 with stop bit 0, line held low 40 cycles -> FRAME_ERR one pulse, VALID stays 0; next frame 0x55 received.
- Frames 0x11 then 0x22 back-to-back, no ACK -> OVERRUN one pulse, RX_OUT=0x22; repeat with ACK in completion cycle -> no OVERRUN.
- RX_EN dropped at data bit 3 -> IDLE, BUSY=0, no VALID; with UART_RX_PARITY_EN, 0x07 sent with parity 0 -> VALID, RX_OUT=0x07, PARITY_ERR pulse.
